// File: rtl/jtag_user_io_shifter.sv
// Byte-per-bit JTAG shifter: one command byte becomes one TCK pulse, TDO optionally returned.
// Bit takes 2*TCK_DIV cycles; capture bits stall in RSP until rsp_ready; disable aborts at once.
module jtag_user_io_shifter #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable_user_jtag_io,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       rsp_ready,
  output logic       jtag_tck,
  output logic       jtag_tms,
  output logic       jtag_tdi,
  input  logic       jtag_tdo,
  output logic       jtag_oe,
  output logic       busy
);

  localparam logic [7:0] CNT_RELOAD = 8'(TCK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, RSP} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tck_q, tck_d;
  logic       tms_q, tms_d;
  logic       tdi_q, tdi_d;
  logic       cap_q, cap_d;
  logic       rsp_vld_q, rsp_vld_d;
  logic       tdo_q, tdo_d;
  logic       oe_q, oe_d;

  logic unused_rsvd;
  assign unused_rsvd = ^cmd_data[7:3];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tck_d     = tck_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    cap_d     = cap_q;
    rsp_vld_d = rsp_vld_q;
    tdo_d     = tdo_q;
    oe_d      = enable_user_jtag_io;
    // Disable overrides everything, including a response handshake this cycle.
    if (!enable_user_jtag_io) begin
      state_d   = IDLE;
      cnt_d     = 8'd0;
      tck_d     = 1'b0;
      tms_d     = 1'b1;
      tdi_d     = 1'b0;
      rsp_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            tms_d   = cmd_data[0];
            tdi_d   = cmd_data[1];
            cap_d   = cmd_data[2];
            tck_d   = 1'b0;
            cnt_d   = CNT_RELOAD;
            state_d = LOW;
          end
        end
        LOW: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            tck_d   = 1'b1;
            tdo_d   = jtag_tdo;
            cnt_d   = CNT_RELOAD;
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            tck_d = 1'b0;
            if (cap_q) begin
              rsp_vld_d = 1'b1;
              state_d   = RSP;
            end else begin
              state_d = IDLE;
            end
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_vld_d = 1'b0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      cap_q     <= 1'b0;
      rsp_vld_q <= 1'b0;
      tdo_q     <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      cap_q     <= cap_d;
      rsp_vld_q <= rsp_vld_d;
      tdo_q     <= tdo_d;
      oe_q      <= oe_d;
    end
  end

  assign cmd_ready = (state_q == IDLE) && enable_user_jtag_io;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_vld_q;
  assign rsp_data  = {7'b0, tdo_q};
  assign jtag_tck  = tck_q;
  assign jtag_tms  = tms_q;
  assign jtag_tdi  = tdi_q;
  assign jtag_oe   = oe_q;

endmodule

// File: tb/tb_jtag_user_io_shifter.sv
// Randomized bench for jtag_user_io_shifter: per-bit pin timing checked in the driver,
// responses checked by a scoreboard monitor against expectations queued at accept time.
module tb_jtag_user_io_shifter;

  localparam int DIV = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready;
  logic       jtag_tck, jtag_tms, jtag_tdi, jtag_tdo, jtag_oe, busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int tck_rises = 0;
  logic tck_prev = 1'b0;
  int rdy_mode = 0;  // 0 random, 1 hold low, 2 hold high, 3 manual
  logic [7:0] exp_q[$];

  jtag_user_io_shifter #(.TCK_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .enable_user_jtag_io(enable),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
    .jtag_tdo(jtag_tdo), .jtag_oe(jtag_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) rsp_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 1) rsp_ready = 1'b0;
    else if (rdy_mode == 2) rsp_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (jtag_tck && !tck_prev) tck_rises++;
    tck_prev = jtag_tck;
  end

  // Response monitor: pops on every handshake that the DUT honours (enable high).
  logic       hold_pend = 1'b0;
  logic [7:0] hold_dat = 8'h00;
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) chk("rsp_hold", {23'b0, rsp_valid, rsp_data}, {23'b0, 1'b1, hold_dat});
      if (rsp_valid && rsp_ready && enable) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else chk("rsp_data", {24'b0, rsp_data}, {24'b0, exp_q.pop_front()});
        hold_pend = 1'b0;
      end else begin
        hold_pend = rsp_valid && enable;
        hold_dat  = rsp_data;
      end
    end
  end

  // Issue one command (called just after a clock edge). Returns after the accept edge,
  // or after the whole bit period when pin checking is requested.
  task automatic send(input logic [7:0] cmd, input logic tdo, input bit push,
                      input bit check, output int acc_cyc);
    int n = 0;
    logic cap;
    logic [5:0] exp_pins;
    cap = cmd[2];
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    jtag_tdo  = tdo;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    acc_cyc = -1;
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc_cyc   = cyc;
      cmd_valid = 1'b0;
      cmd_data  = 8'($urandom);
      if (push && cap) exp_q.push_back({7'b0, tdo});
      if (check) begin
        for (int k = 0; k <= 2 * DIV; k++) begin
          exp_pins = {(k >= DIV) && (k < 2 * DIV), cmd[0], cmd[1],
                      (k < 2 * DIV) || cap, (k == 2 * DIV) && !cap, (k == 2 * DIV) && cap};
          chk($sformatf("pins_k%0d_cmd%02h", k, cmd),
              {26'b0, jtag_tck, jtag_tms, jtag_tdi, busy, cmd_ready, rsp_valid},
              {26'b0, exp_pins});
          if (k < 2 * DIV) begin
            @(posedge clk); #1;
          end
        end
      end
    end
  endtask

  task automatic chk_disabled(input string name, input logic oe_exp);
    chk(name, {28'b0, jtag_tck, jtag_tms, jtag_tdi, busy},  {28'b0, 4'b0100});
    chk({name, "_rsp"}, {30'b0, rsp_valid, cmd_ready}, 32'd0);
    chk({name, "_oe"}, {31'b0, jtag_oe}, {31'b0, oe_exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int acc;
    int acc_prev;
    int rises0;
    int n;
    reset_n = 1'b0; enable = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
    jtag_tdo = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vals", {17'b0, jtag_tck, jtag_tms, jtag_tdi, jtag_oe, rsp_valid, rsp_data, busy, cmd_ready},
        {17'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("disabled_ready", {30'b0, cmd_ready, jtag_oe}, 32'd0);

    // Enable: ready rises in the same cycle, oe one edge later.
    enable = 1'b1;
    #1 chk("enable_ready_comb", {30'b0, cmd_ready, jtag_oe}, {30'b0, 2'b10});
    @(posedge clk); #1;
    chk("oe_follows", {31'b0, jtag_oe}, 32'd1);

    // Directed single capture: TDI=1, TMS=0, TDO=1 -> rsp 0x01.
    rdy_mode = 0;
    send(8'h06, 1'b1, 1'b1, 1'b1, acc);

    // Burst of non-capture bits, accepts spaced 2*DIV+1.
    n = 0;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    rises0 = tck_rises;
    acc_prev = -1;
    for (int i = 0; i < 5; i++) begin
      send(8'h01, 1'($urandom), 1'b1, 1'b1, acc);
      if (acc_prev >= 0) chk("burst_spacing", acc - acc_prev, 2 * DIV + 1);
      acc_prev = acc;
    end
    @(negedge clk);
    chk("burst_tck_pulses", tck_rises - rises0, 5);

    // Randomized command stream with random response backpressure.
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, acc);
    end
    n = 0;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end

    // Response backpressure for 10 cycles.
    rdy_mode = 1;
    @(posedge clk); #1;
    send(8'h04, 1'b1, 1'b1, 1'b1, acc);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {29'b0, rsp_valid, rsp_data[0], cmd_ready}, {29'b0, 3'b110});
    end
    rdy_mode = 2;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {30'b0, rsp_valid, cmd_ready}, {30'b0, 2'b01});

    // Disable while in LOW: bit aborted, no response.
    rdy_mode = 0;
    send(8'h07, 1'b1, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    chk("low_before_disable", {30'b0, jtag_tck, busy}, {30'b0, 2'b01});
    enable = 1'b0;
    @(posedge clk); #1;
    chk_disabled("dis_low", 1'b0);
    repeat (2 * DIV + 2) @(posedge clk);
    #1 chk("dis_low_no_rsp", {31'b0, rsp_valid}, 32'd0);
    enable = 1'b1;
    #1 chk("reenable_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Disable in RSP coinciding with rsp_ready: response discarded.
    rdy_mode = 1;
    @(posedge clk); #1;
    send(8'h04, 1'b0, 1'b0, 1'b1, acc);
    rdy_mode = 3;
    rsp_ready = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    chk_disabled("dis_rsp", 1'b0);
    enable = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;

    // Asynchronous reset mid-HIGH with a captured 1 in rsp_data.
    send(8'h07, 1'b1, 1'b0, 1'b0, acc);
    repeat (DIV) @(posedge clk);
    #1 chk("pre_reset_high", {30'b0, jtag_tck, rsp_data[0]}, {30'b0, 2'b11});
    #2 reset_n = 1'b0;
    enable = 1'b0;
    #1 chk("async_reset", {17'b0, jtag_tck, jtag_tms, jtag_tdi, jtag_oe, rsp_valid, rsp_data, busy, cmd_ready},
           {17'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    #13 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", {30'b0, cmd_ready, busy}, 32'd0);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    chk("rsp_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
